mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the CPU's two memory interfaces: instruction fetch (PC port) and load/store port.
- Serves both from one single-ported synchronous RAM, with a programmable wait-state count.
- Arbitrates between the two ports: load/store has priority over fetch.
- Decodes one memory-mapped I/O word: LED output register on stores, switch input on loads.

Parameters:
- WIDTH, 16, data and address width in bits.
- ADDR_BITS, 10, RAM index width; RAM depth is 2^ADDR_BITS words.
- WAIT_STATES, 1, extra cycles per access; legal range 0..15.
- IO_ADDR, 16'hFFFF, full-width address decoded as the I/O word.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  level request to fetch the word at mem_address_PC.
- mem_address_PC  in  WIDTH  fetch address.
- data_from_mem_PC  out  WIDTH  fetched word; valid while fetch_valid=1.
- fetch_valid  out  1  one-cycle pulse: fetch complete.
- write_to_memory  in  1  store request.
- reading_for_load  in  1  load request.
- mem_address_load_stor  in  WIDTH  load/store address.
- data_to_mem_stor  in  WIDTH  store data.
- data_from_mem_load  out  WIDTH  load result; valid while ls_valid=1.
- ls_valid  out  1  one-cycle pulse: load or store complete.
- busy  out  1  high while an access is in progress (state is not IDLE).
- switches  in  WIDTH  board input returned by loads from IO_ADDR.
- leds  out  WIDTH  register written by stores to IO_ADDR.

Behaviour:
- Reset: state=IDLE, counter=0, fetch_valid=0, ls_valid=0, busy=0, data_from_mem_PC=0, data_from_mem_load=0, leds=0.
  - RAM contents are not cleared.
  - Reset during BUSY aborts the access: no RAM or leds write occurs, and no valid pulse is issued.
- States: IDLE, BUSY_LS, BUSY_FETCH.
- IDLE, at each edge:
  - If write_to_memory or reading_for_load is high: latch address, store data and type; load counter with WAIT_STATES; go to BUSY_LS.
  - Else if fetch_req is high: latch mem_address_PC; load counter; go to BUSY_FETCH.
  - Else stay in IDLE.
- Priority and operation type:
  - Load/store beats fetch. A fetch that loses stays pending because fetch_req is a level; it is served on the next IDLE edge with no load/store request.
  - write_to_memory and reading_for_load both high: the access is a store.
- BUSY_*:
  - counter != 0: decrement.
  - counter == 0: perform the access on this edge, register the result, pulse the matching valid for the next cycle, return to IDLE.
- Latency: a request first present in IDLE cycle c produces valid in cycle c+WAIT_STATES+2. busy is high in cycles c+1 .. c+WAIT_STATES+1.
- Back-to-back requests:
  - The valid cycle is spent in IDLE, so a request held high during the valid cycle is accepted as a new request at the following edge.
  - A requester that is finished must drop its request in the valid cycle.
- Store semantics:
  - A store writes RAM at the access edge.
  - A load issued afterwards sees the new data; there is no read-before-write hazard.
- Address handling:
  - The I/O decode compares the full WIDTH-bit latched address against IO_ADDR.
  - Non-I/O addresses are truncated to the low ADDR_BITS, so addresses wrap modulo depth.
- I/O:
  - Store to IO_ADDR updates leds only; RAM is unchanged.
  - Load from IO_ADDR returns switches, sampled at the access edge.
  - Fetch ignores the I/O decode and always reads RAM.
- Output hold: data_from_mem_PC and data_from_mem_load hold their last values outside valid cycles.
- Stores pulse ls_valid; data_from_mem_load is unchanged by a store.
- Request inputs are ignored while busy. Latched values are used, so requesters need not hold address or data after acceptance.

Test Plan:
- Reset asserted mid-cycle with no clock edge -> all outputs 0 immediately; leds=0.
- WAIT_STATES=1: store 16'h1234 to 16'h0005 in cycle c -> busy in c+1..c+2, ls_valid only in c+3. Then load 16'h0005 -> data_from_mem_load=16'h1234 with ls_valid in the 3rd cycle after the request.
- fetch_req and reading_for_load both high in cycle c, WAIT_STATES=1 -> ls_valid in c+3, fetch_valid in c+6, both one cycle wide.
- Store 16'h00A5 to 16'hFFFF -> leds=16'h00A5; RAM[10'h3FF] unchanged. Load 16'hFFFF with switches=16'h0F0F -> data_from_mem_load=16'h0F0F.
- ADDR_BITS=10: store 16'hBEEF to 16'h0400, then load 16'h0000 -> 16'hBEEF.
- Store 16'h5555 to 16'h0010 (RAM holds 16'h0000), reset pulsed during BUSY_LS -> no ls_valid; a later load of 16'h0010 returns 16'h0000.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Single-ported RAM responder shared by instruction fetch and
//            load/store ports, with wait states and one memory-mapped I/O word.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int                WIDTH       = 16,
  parameter int                ADDR_BITS   = 10,
  parameter int                WAIT_STATES = 1,
  parameter logic [WIDTH-1:0]  IO_ADDR     = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_req,
  input  logic [WIDTH-1:0] mem_address_PC,
  output logic [WIDTH-1:0] data_from_mem_PC,
  output logic             fetch_valid,
  input  logic             write_to_memory,
  input  logic             reading_for_load,
  input  logic [WIDTH-1:0] mem_address_load_stor,
  input  logic [WIDTH-1:0] data_to_mem_stor,
  output logic [WIDTH-1:0] data_from_mem_load,
  output logic             ls_valid,
  output logic             busy,
  input  logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] leds
);

  localparam int         c_depth      = 2 ** ADDR_BITS;
  localparam logic [3:0] c_wait       = 4'(WAIT_STATES);
  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_busy_ls = 2'd1;
  localparam logic [1:0] c_st_busy_fe = 2'd2;

  logic [1:0]           r_state;
  logic [3:0]           r_count;
  logic [WIDTH-1:0]     r_addr;
  logic [WIDTH-1:0]     r_wdata;
  logic                 r_is_store;
  logic [WIDTH-1:0]     r_mem [0:c_depth-1];
  logic [WIDTH-1:0]     r_pc_data;
  logic [WIDTH-1:0]     r_ld_data;
  logic                 r_fetch_valid;
  logic                 r_ls_valid;
  logic [WIDTH-1:0]     r_leds;

  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_is_io;
  logic                 w_access;
  logic                 w_ram_we;
  logic [WIDTH-1:0]     w_ram_rd;

  assign w_idx    = r_addr[ADDR_BITS-1:0];
  assign w_is_io  = (r_addr == IO_ADDR);
  assign w_access = (r_state != c_st_idle) && (r_count == 4'd0);
  // State is cleared asynchronously, so a reset mid-access also kills the write.
  assign w_ram_we = w_access && (r_state == c_st_busy_ls) && r_is_store && !w_is_io;
  assign w_ram_rd = r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (w_ram_we)
      r_mem[w_idx] <= r_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= c_st_idle;
      r_count       <= 4'd0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_is_store    <= 1'b0;
      r_pc_data     <= '0;
      r_ld_data     <= '0;
      r_fetch_valid <= 1'b0;
      r_ls_valid    <= 1'b0;
      r_leds        <= '0;
    end else begin
      r_fetch_valid <= 1'b0;
      r_ls_valid    <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (write_to_memory || reading_for_load) begin
            r_addr     <= mem_address_load_stor;
            r_wdata    <= data_to_mem_stor;
            r_is_store <= write_to_memory;
            r_count    <= c_wait;
            r_state    <= c_st_busy_ls;
          end else if (fetch_req) begin
            r_addr  <= mem_address_PC;
            r_count <= c_wait;
            r_state <= c_st_busy_fe;
          end
        end
        c_st_busy_ls: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else begin
            if (r_is_store) begin
              if (w_is_io)
                r_leds <= r_wdata;
            end else begin
              r_ld_data <= w_is_io ? switches : w_ram_rd;
            end
            r_ls_valid <= 1'b1;
            r_state    <= c_st_idle;
          end
        end
        c_st_busy_fe: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else begin
            r_pc_data     <= w_ram_rd;
            r_fetch_valid <= 1'b1;
            r_state       <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign data_from_mem_PC   = r_pc_data;
  assign fetch_valid        = r_fetch_valid;
  assign data_from_mem_load = r_ld_data;
  assign ls_valid           = r_ls_valid;
  assign busy               = (r_state != c_st_idle);
  assign leds               = r_leds;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Directed self-checking bench for mem_responder (WAIT_STATES=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [15:0] mem_address_PC;
  logic [15:0] data_from_mem_PC;
  logic        fetch_valid;
  logic        write_to_memory;
  logic        reading_for_load;
  logic [15:0] mem_address_load_stor;
  logic [15:0] data_to_mem_stor;
  logic [15:0] data_from_mem_load;
  logic        ls_valid;
  logic        busy;
  logic [15:0] switches;
  logic [15:0] leds;

  int n_cmp;
  int n_err;

  mem_responder #(
    .WIDTH(16), .ADDR_BITS(10), .WAIT_STATES(1), .IO_ADDR(16'hFFFF)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .mem_address_PC(mem_address_PC),
    .data_from_mem_PC(data_from_mem_PC), .fetch_valid(fetch_valid),
    .write_to_memory(write_to_memory), .reading_for_load(reading_for_load),
    .mem_address_load_stor(mem_address_load_stor), .data_to_mem_stor(data_to_mem_stor),
    .data_from_mem_load(data_from_mem_load), .ls_valid(ls_valid), .busy(busy),
    .switches(switches), .leds(leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (start of next cycle).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one load/store, drop it after acceptance, wait for ls_valid.
  task automatic ls_access(input string tag, input logic st, input logic [15:0] a,
                           input logic [15:0] d, input int exp_lat);
    int lat;
    write_to_memory       = st;
    reading_for_load      = ~st;
    mem_address_load_stor = a;
    data_to_mem_stor      = d;
    step();
    write_to_memory  = 1'b0;
    reading_for_load = 1'b0;
    lat = 1;
    while (!ls_valid && lat < 20) begin
      step();
      lat++;
    end
    check_val({tag, "_lat"}, 16'(lat), 16'(exp_lat));
  endtask

  initial begin
    int seen;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    fetch_req = 1'b0;
    mem_address_PC = '0;
    write_to_memory = 1'b0;
    reading_for_load = 1'b0;
    mem_address_load_stor = '0;
    data_to_mem_stor = '0;
    switches = 16'h0F0F;

    // Asynchronous reset between edges clears outputs without a clock edge.
    #2 reset = 1'b1;
    #1;
    check_val("rst_pc",    data_from_mem_PC, 16'h0000);
    check_val("rst_ld",    data_from_mem_load, 16'h0000);
    check_val("rst_fv",    16'(fetch_valid), 16'h0);
    check_val("rst_lv",    16'(ls_valid), 16'h0);
    check_val("rst_busy",  16'(busy), 16'h0);
    check_val("rst_leds",  leds, 16'h0000);
    step();
    step();
    reset = 1'b0;
    step();

    // Cycle-exact store: request in cycle c.
    write_to_memory       = 1'b1;
    mem_address_load_stor = 16'h0005;
    data_to_mem_stor      = 16'h1234;
    check_val("st_c0_busy", 16'(busy), 16'h0);
    step();
    write_to_memory = 1'b0;
    check_val("st_c1_busy", 16'(busy), 16'h1);
    check_val("st_c1_lv",   16'(ls_valid), 16'h0);
    step();
    check_val("st_c2_busy", 16'(busy), 16'h1);
    check_val("st_c2_lv",   16'(ls_valid), 16'h0);
    step();
    check_val("st_c3_busy", 16'(busy), 16'h0);
    check_val("st_c3_lv",   16'(ls_valid), 16'h1);
    check_val("st_ld_hold", data_from_mem_load, 16'h0000);
    step();
    check_val("st_c4_lv",   16'(ls_valid), 16'h0);

    ls_access("ld5", 1'b0, 16'h0005, 16'h0000, 3);
    check_val("ld5_data", data_from_mem_load, 16'h1234);
    step();
    check_val("ld5_hold", data_from_mem_load, 16'h1234);

    // Load beats fetch; the pending fetch is served afterwards.
    mem_address_PC        = 16'h0005;
    fetch_req             = 1'b1;
    reading_for_load      = 1'b1;
    mem_address_load_stor = 16'h0005;
    step(); reading_for_load = 1'b0;              // c+1
    check_val("arb_c1_busy", 16'(busy), 16'h1);
    step();                                        // c+2
    check_val("arb_c2_lv", 16'(ls_valid), 16'h0);
    step();                                        // c+3
    check_val("arb_c3_lv", 16'(ls_valid), 16'h1);
    check_val("arb_c3_fv", 16'(fetch_valid), 16'h0);
    step();                                        // c+4
    check_val("arb_c4_lv", 16'(ls_valid), 16'h0);
    check_val("arb_c4_busy", 16'(busy), 16'h1);
    step();                                        // c+5
    check_val("arb_c5_fv", 16'(fetch_valid), 16'h0);
    step();                                        // c+6
    fetch_req = 1'b0;
    check_val("arb_c6_fv", 16'(fetch_valid), 16'h1);
    check_val("arb_pc",    data_from_mem_PC, 16'h1234);
    step();
    check_val("arb_c7_fv", 16'(fetch_valid), 16'h0);

    // I/O word: RAM[3FF] must survive a store to FFFF.
    ls_access("st3ff", 1'b1, 16'h03FF, 16'h7777, 3);
    ls_access("stio",  1'b1, 16'hFFFF, 16'h00A5, 3);
    check_val("leds", leds, 16'h00A5);
    ls_access("ld3ff", 1'b0, 16'h03FF, 16'h0000, 3);
    check_val("ram3ff_kept", data_from_mem_load, 16'h7777);
    ls_access("ldio",  1'b0, 16'hFFFF, 16'h0000, 3);
    check_val("ldio_sw", data_from_mem_load, 16'h0F0F);

    // Fetch bypasses I/O decode and wraps into RAM.
    mem_address_PC = 16'hFFFF;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    seen = 1;
    while (!fetch_valid && seen < 20) begin
      step();
      seen++;
    end
    check_val("fe_io_lat", 16'(seen), 16'd3);
    check_val("fe_io_ram", data_from_mem_PC, 16'h7777);

    // Address wrap modulo depth.
    ls_access("stwrap", 1'b1, 16'h0400, 16'hBEEF, 3);
    ls_access("ldwrap", 1'b0, 16'h0000, 16'h0000, 3);
    check_val("wrap_data", data_from_mem_load, 16'hBEEF);

    // Reset during BUSY_LS aborts the store.
    ls_access("st10z", 1'b1, 16'h0010, 16'h0000, 3);
    step();
    write_to_memory       = 1'b1;
    mem_address_load_stor = 16'h0010;
    data_to_mem_stor      = 16'h5555;
    step();
    write_to_memory = 1'b0;
    check_val("ab_busy", 16'(busy), 16'h1);
    #2 reset = 1'b1;
    #1;
    check_val("ab_busy_clr", 16'(busy), 16'h0);
    check_val("ab_leds_clr", leds, 16'h0000);
    #2 reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ls_valid) seen++;
    end
    check_val("ab_no_lv", 16'(seen), 16'h0);
    ls_access("ld10", 1'b0, 16'h0010, 16'h0000, 3);
    check_val("ab_ram_kept", data_from_mem_load, 16'h0000);

    // Store+load both high counts as a store.
    write_to_memory = 1'b1;
    reading_for_load = 1'b1;
    mem_address_load_stor = 16'h0020;
    data_to_mem_stor = 16'hC0DE;
    step();
    write_to_memory = 1'b0;
    reading_for_load = 1'b0;
    step(); step();
    check_val("both_lv", 16'(ls_valid), 16'h1);
    check_val("both_ld_hold", data_from_mem_load, 16'h0000);
    ls_access("ld20", 1'b0, 16'h0020, 16'h0000, 3);
    check_val("both_stored", data_from_mem_load, 16'hC0DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
